// File: rtl/input_pixel_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// input_pixel_fetch_if : start/status, image-RAM read port and pixel stream
// Revision 1.0
// ----------------------------------------------------------------------------
interface input_pixel_fetch_if #(
    parameter int RC_W = 8
);
    logic                   start;
    logic [15:0]            base_addr;
    logic                   busy;
    logic                   done;
    logic [15:0]            mem_addr;
    logic                   mem_wen;
    logic [31:0]            mem_d;
    logic [31:0]            mem_q;
    logic                   pix_valid;
    logic                   pix_ready;
    logic signed [7:0]      pix_data;
    logic [RC_W-1:0]        pix_row;
    logic [RC_W-1:0]        pix_col;
    logic                   pix_sol;
    logic                   pix_last;

    modport master (
        input  start, base_addr, mem_q, pix_ready,
        output busy, done, mem_addr, mem_wen, mem_d,
               pix_valid, pix_data, pix_row, pix_col, pix_sol, pix_last
    );

    modport slave (
        output start, base_addr, mem_q, pix_ready,
        input  busy, done, mem_addr, mem_wen, mem_d,
               pix_valid, pix_data, pix_row, pix_col, pix_sol, pix_last
    );
endinterface
`default_nettype wire

// File: rtl/input_pixel_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// input_pixel_fetch : row-major image reader, 32-bit RAM words -> pixel stream
// Revision 1.0
// ----------------------------------------------------------------------------
module input_pixel_fetch #(
    parameter int IMG_H = 64,
    parameter int IMG_W = 64,
    parameter int RC_W  = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input_pixel_fetch_if.master bus
);

    localparam int              N         = IMG_H * IMG_W;
    localparam int              NW        = (N + 3) / 4;
    localparam logic [16:0]     LAST_PIX  = 17'(N - 1);
    localparam logic [16:0]     NUM_WORDS = 17'(NW);
    localparam logic [RC_W-1:0] COL_MAX   = RC_W'(IMG_W - 1);
    localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     addr_q;
    logic            addr_ph_q;
    logic            data_ph_q;
    logic [16:0]     rd_cnt_q;
    logic [16:0]     pix_cnt_q;
    logic [RC_W-1:0] row_q;
    logic [RC_W-1:0] col_q;
    logic [31:0]     cur_q,     cur_d;
    logic            cur_vld_q, cur_vld_d;
    logic [31:0]     nxt_q,     nxt_d;
    logic            nxt_vld_q, nxt_vld_d;

    logic            w_hs;
    logic            w_final_pix;
    logic            w_cur_done;
    logic            w_issue;
    logic [7:0]      w_byte;

    // The byte index within cur is the low two bits of the pixel counter,
    // since every word starts on a pixel index that is a multiple of four.
    always_comb begin
        w_hs        = cur_vld_q & bus.pix_ready;
        w_final_pix = (pix_cnt_q == LAST_PIX);
        w_cur_done  = w_hs & ((pix_cnt_q[1:0] == 2'd3) | w_final_pix);
        w_issue     = (state_q == S_RUN) & (rd_cnt_q < NUM_WORDS) &
                      ~addr_ph_q & ~data_ph_q & ~nxt_vld_q;
        case (pix_cnt_q[1:0])
            2'd0:    w_byte = cur_q[7:0];
            2'd1:    w_byte = cur_q[15:8];
            2'd2:    w_byte = cur_q[23:16];
            default: w_byte = cur_q[31:24];
        endcase
    end

    always_comb begin
        cur_d     = cur_q;
        cur_vld_d = cur_vld_q;
        nxt_d     = nxt_q;
        nxt_vld_d = nxt_vld_q;
        if (!cur_vld_q || w_cur_done) begin
            if (nxt_vld_q) begin
                cur_d     = nxt_q;
                cur_vld_d = 1'b1;
                nxt_vld_d = data_ph_q;
                if (data_ph_q) begin
                    nxt_d = bus.mem_q;
                end
            end else if (data_ph_q) begin
                cur_d     = bus.mem_q;
                cur_vld_d = 1'b1;
            end else begin
                cur_vld_d = 1'b0;
            end
        end else if (data_ph_q) begin
            nxt_d     = bus.mem_q;
            nxt_vld_d = 1'b1;
        end
    end

    // addr_ph: mem_addr carries a live read this cycle; data_ph: mem_q is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= 16'd0;
            addr_ph_q <= 1'b0;
            data_ph_q <= 1'b0;
            rd_cnt_q  <= 17'd0;
            pix_cnt_q <= 17'd0;
            row_q     <= '0;
            col_q     <= '0;
            cur_q     <= 32'd0;
            cur_vld_q <= 1'b0;
            nxt_q     <= 32'd0;
            nxt_vld_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            data_ph_q <= addr_ph_q;
            addr_ph_q <= 1'b0;
            cur_q     <= cur_d;
            cur_vld_q <= cur_vld_d;
            nxt_q     <= nxt_d;
            nxt_vld_q <= nxt_vld_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                        addr_q    <= bus.base_addr;
                        addr_ph_q <= 1'b1;
                        rd_cnt_q  <= 17'd1;
                        pix_cnt_q <= 17'd0;
                        row_q     <= '0;
                        col_q     <= '0;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        addr_q    <= addr_q + 16'd4;
                        addr_ph_q <= 1'b1;
                        rd_cnt_q  <= rd_cnt_q + 17'd1;
                    end
                    if (w_hs) begin
                        pix_cnt_q <= pix_cnt_q + 17'd1;
                        if (col_q == COL_MAX) begin
                            col_q <= '0;
                            row_q <= row_q + RC_ONE;
                        end else begin
                            col_q <= col_q + RC_ONE;
                        end
                        if (w_final_pix) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = 1'b0;
    assign bus.mem_d     = 32'd0;
    assign bus.pix_valid = cur_vld_q;
    assign bus.pix_data  = cur_vld_q ? w_byte : 8'd0;
    assign bus.pix_row   = row_q;
    assign bus.pix_col   = col_q;
    assign bus.pix_sol   = cur_vld_q & (col_q == '0);
    assign bus.pix_last  = cur_vld_q & w_final_pix;

endmodule
`default_nettype wire

// File: tb/tb_input_pixel_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_input_pixel_fetch : scoreboard bench for 4x4 and 3x3 instances
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_input_pixel_fetch;

    localparam int RC_W = 8;

    typedef struct packed {
        logic [7:0]      d;
        logic [RC_W-1:0] r;
        logic [RC_W-1:0] c;
        logic            sol;
        logic            last;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st;
    logic [15:0] base;
    logic        pr;
    logic        sel;
    logic [7:0]  ram_off;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    pix_t sb[$];

    always #5 clk = ~clk;

    input_pixel_fetch_if #(.RC_W(RC_W)) if44 ();
    input_pixel_fetch_if #(.RC_W(RC_W)) if33 ();

    input_pixel_fetch #(.IMG_H(4), .IMG_W(4), .RC_W(RC_W)) u_dut44 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if44.master)
    );

    input_pixel_fetch #(.IMG_H(3), .IMG_W(3), .RC_W(RC_W)) u_dut33 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if33.master)
    );

    assign if44.start     = st & ~sel;
    assign if33.start     = st & sel;
    assign if44.base_addr = base;
    assign if33.base_addr = base;
    assign if44.pix_ready = pr;
    assign if33.pix_ready = pr;

    function automatic logic [7:0] bval(input logic [15:0] a);
        return a[7:0] + ram_off;
    endfunction

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {bval(a + 16'd3), bval(a + 16'd2), bval(a + 16'd1), bval(a)};
    endfunction

    // One-cycle read latency RAM model
    always @(posedge clk) begin
        if44.mem_q <= word_at(if44.mem_addr);
        if33.mem_q <= word_at(if33.mem_addr);
    end

    logic              m_pv, m_busy, m_done, m_sol, m_last, m_wen;
    logic [15:0]       m_addr;
    logic [7:0]        m_data;
    logic [RC_W-1:0]   m_row, m_col;
    logic [31:0]       m_memd;

    always_comb begin
        m_pv   = sel ? if33.pix_valid : if44.pix_valid;
        m_busy = sel ? if33.busy      : if44.busy;
        m_done = sel ? if33.done      : if44.done;
        m_sol  = sel ? if33.pix_sol   : if44.pix_sol;
        m_last = sel ? if33.pix_last  : if44.pix_last;
        m_wen  = sel ? if33.mem_wen   : if44.mem_wen;
        m_addr = sel ? if33.mem_addr  : if44.mem_addr;
        m_data = sel ? if33.pix_data  : if44.pix_data;
        m_row  = sel ? if33.pix_row   : if44.pix_row;
        m_col  = sel ? if33.pix_col   : if44.pix_col;
        m_memd = sel ? if33.mem_d     : if44.mem_d;
    end

    pix_t prev;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin
        pix_t act;
        pix_t exp;
        act = {m_data, m_row, m_col, m_sol, m_last};
        if (rst_n) begin
            if (prev_stall) begin
                n_tests++;
                if (act !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold act=%h exp=%h", act, prev);
                end
            end
            if (m_pv && pr) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_pixel act=%h exp=none", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL pixel act=%h exp=%h", act, exp);
                    end
                end
            end
            if (m_done) begin
                done_cnt++;
                n_tests++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL done_early act=%0d_pending exp=0_pending", sb.size());
                end
            end
            prev_stall = m_pv && !pr;
            prev       = act;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push_expected(input int n, input int w, input logic [15:0] b);
        for (int k = 0; k < n; k++) begin
            pix_t        p;
            logic [15:0] a;
            a      = b + 16'(k);
            p.d    = a[7:0] + ram_off;
            p.r    = RC_W'(k / w);
            p.c    = RC_W'(k % w);
            p.sol  = ((k % w) == 0);
            p.last = (k == n - 1);
            sb.push_back(p);
        end
    endtask

    // Full run with pix_ready=1, checking cycle-exact latency, addresses and done
    task automatic run_timed(input logic s, input logic [15:0] b, input int h, input int w,
                             input logic glitch);
        int n;
        int nw;
        int done0;
        n     = h * w;
        nw    = (n + 3) / 4;
        sel   = s;
        base  = b;
        pr    = 1'b1;
        done0 = done_cnt;
        push_expected(n, w, b);
        st = 1'b1;
        tick();
        for (int c = 1; c <= n + 6; c++) begin
            if (glitch && (c == 5 || c == n + 3)) begin
                st   = 1'b1;
                base = 16'h1234;
            end else begin
                st = 1'b0;
            end
            chk("pix_valid", {31'd0, m_pv},   {31'd0, (c >= 3 && c <= n + 2)});
            chk("busy",      {31'd0, m_busy}, {31'd0, (c >= 1 && c <= n + 2)});
            chk("done",      {31'd0, m_done}, {31'd0, (c == n + 3)});
            for (int k = 0; k < nw; k++) begin
                if (c == ((k == 0) ? 1 : 4 * k))
                    chk("mem_addr", {16'd0, m_addr}, {16'd0, b + 16'(4 * k)});
            end
            if (c == n + 6)
                chk("mem_addr_final", {16'd0, m_addr}, {16'd0, b + 16'(4 * (nw - 1))});
            tick();
        end
        st = 1'b0;
        chk("done_count", done_cnt, done0 + 1);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic run_toggle();
        int done0;
        sel   = 1'b0;
        base  = 16'h0040;
        done0 = done_cnt;
        push_expected(16, 4, 16'h0040);
        st = 1'b1;
        tick();
        st = 1'b0;
        for (int c = 1; c < 100 && done_cnt == done0; c++) begin
            pr = c[0];
            tick();
        end
        pr = 1'b1;
        chk("toggle_done", done_cnt, done0 + 1);
        chk("toggle_sb_empty", sb.size(), 0);
        tick();
    endtask

    task automatic run_reset();
        int done0;
        sel   = 1'b0;
        base  = 16'h0000;
        pr    = 1'b1;
        done0 = done_cnt;
        push_expected(16, 4, 16'h0000);
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (7) tick();
        chk("sixth_pixel_valid", {31'd0, m_pv}, 32'd1);
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk("rst_ctrl", {28'd0, m_busy, m_done, m_pv, m_sol}, 32'd0);
        chk("rst_last_addr", {15'd0, m_last, m_addr}, 32'd0);
        chk("rst_data_rc", {8'd0, m_data, m_row, m_col}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_done_after_abort", done_cnt, done0);
        run_timed(1'b0, 16'h0000, 4, 4, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        st      = 1'b0;
        base    = 16'h0000;
        pr      = 1'b1;
        sel     = 1'b0;
        ram_off = 8'h00;
        repeat (3) tick();
        chk("reset44", {if44.busy, if44.done, if44.pix_valid, if44.pix_sol, if44.pix_last,
                        11'd0, if44.mem_addr}, 32'd0);
        chk("reset44_data", {8'd0, if44.pix_data, if44.pix_row, if44.pix_col}, 32'd0);
        chk("reset33", {if33.busy, if33.done, if33.pix_valid, if33.pix_sol, if33.pix_last,
                        11'd0, if33.mem_addr}, 32'd0);
        chk("tied_off", {m_wen, m_memd[30:0]} | {31'd0, m_memd[31]}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_timed(1'b0, 16'h0000, 4, 4, 1'b0);
        run_toggle();
        ram_off = 8'h80;
        run_timed(1'b1, 16'h0000, 3, 3, 1'b0);
        ram_off = 8'h00;
        run_timed(1'b0, 16'hFFF8, 4, 4, 1'b0);
        run_reset();
        run_timed(1'b0, 16'h0100, 4, 4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_pixel_fetch.md
Name: input_pixel_fetch

Overview:
Read-side initiator for the input image RAM. On a start pulse it walks an IMG_H x IMG_W signed 8-bit image in row-major order and issues 32-bit word reads at byte addresses base, base+4, and so on. Each returned word is unpacked little-endian into four pixels on a valid/ready stream that feeds the FFT row-transform front end. Prefetch buffering sustains 1 pixel/cycle when the consumer never stalls.

Parameters:
IMG_H, 64, image height in rows (1..256)
IMG_W, 64, image width in pixels (1..256); IMG_H*IMG_W <= 65536
RC_W, 8, width of row/col index outputs; must satisfy 2^RC_W >= max(IMG_H, IMG_W)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to fetch the whole image; ignored while busy=1
base_addr  in  16  byte address of pixel (0,0); sampled on the accepted start
busy  out  1  high from the cycle after the accepted start until done
done  out  1  one-cycle pulse in the cycle after the last pixel handshake
mem_addr  out  16  registered read byte address to the RAM
mem_wen  out  1  tied 0 (read-only master)
mem_d  out  32  tied 0
mem_q  in  32  RAM read data; {byte A+3, A+2, A+1, A}
pix_valid  out  1  pixel available
pix_ready  in  1  consumer accepts; handshake = pix_valid & pix_ready
pix_data  out  8  signed pixel
pix_row  out  RC_W  row of current pixel
pix_col  out  RC_W  column of current pixel
pix_sol  out  1  high when pix_col==0
pix_last  out  1  high on the final pixel (IMG_H-1, IMG_W-1)

Behaviour:
- Reset (rst_n=0 at an edge): FSM to IDLE. busy=0, done=0, pix_valid=0, mem_addr=0, pix_data/row/col=0, pix_sol=0, pix_last=0. Both word buffers and the in-flight flag are cleared. Reset mid-image aborts the transfer with no done pulse. Any RAM read in flight is discarded.
- RAM timing: an address presented on mem_addr in cycle t yields valid mem_q in cycle t+1. The word is captured at the end of cycle t+1.
- Counts: N = IMG_H*IMG_W pixels; NW = ceil(N/4) word reads. Addresses are base_addr+4k, k=0..NW-1, and wrap modulo 2^16.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches base, zeroes counters, goes to RUN.
  - RUN: issue reads and emit pixels. After the last pixel handshake, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Buffers: cur word plus byte index bi (0..3), and a next-word buffer nxt. At most one read is in flight.
- Issue rule: issue in any RUN cycle where reads_issued < NW, no read is in flight, and nxt is empty. A captured word goes to cur if cur is empty, otherwise to nxt.
- Pixel output:
  - pix_data = cur byte bi, where bi=0 maps to mem_q[7:0].
  - On a handshake, bi advances. After byte 3, or after the final valid byte of a partial last word, cur loads nxt (or an arriving word) in the same edge.
  - pix_valid stays high while cur is valid. No bubble between words when pix_ready=1.
- Partial final word: when N mod 4 = r != 0, only bytes 0..r-1 of the last word are emitted; the rest are dropped.
- Row/col:
  - col increments per handshake and wraps to 0 at IMG_W-1; row then increments.
  - Row/col are independent of word boundaries, so a word may straddle rows.
- Stall: with pix_valid=1 and pix_ready=0, pix_data/row/col/sol/last hold stable. Fetching stops once nxt is full.
- Latency: start high in cycle 0 -> mem_addr=base in cycle 1 -> first pix_valid in cycle 3.
- start while busy: ignored. start during the DONE cycle: ignored.

Test Plan:
- IMG_H=4, IMG_W=4, base=0x0000, RAM bytes 0..15 = 0x00..0x0F, pix_ready=1 -> pix_valid high in cycles 3..18. Data is 0x00..0x0F in order, mem_addr = 0,4,8,12. pix_sol on pixels 0,4,8,12; pix_last on the 16th. done in cycle 19.
- Same image with pix_ready toggling 1,0 -> 16 pixels, no duplicates or losses, outputs stable during stalls, at most 2 words buffered. done follows the last handshake.
- IMG_H=3, IMG_W=3 (N=9, NW=3), bytes 0x80,0x81,... -> 9 pixels 0x80..0x88 (signed -128..-120). 3 reads; bytes 9..11 are never emitted.
- base=0xFFF8, 4x4 image -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004 (wrap), with correct byte order.
- rst_n low during the 6th pixel -> next cycle all outputs 0, no done. A new start fetches from pixel 0 with correct latency.
- start asserted again while busy -> no effect on addresses, counters or pixel sequence.
